// File: rtl/hist2d_accum_ctrl.sv
// 2-D histogram accumulator: clears its bin memory, counts binned samples, then streams and clears it on request.
// Optional macro HIST2D_OOR_COUNT_EN enables the out-of-range sample counter (oor_count is 0 otherwise).
module hist2d_accum_ctrl #(
  parameter int COORD_W = 4,
  parameter int COUNT_W = 16
) (
  input  logic                   clk100,
  input  logic                   rst_n,
  input  logic                   bin_valid,
  input  logic [COORD_W-1:0]     i_bin_coord,
  input  logic [COORD_W-1:0]     q_bin_coord,
  input  logic                   start_dump,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [2*COORD_W-1:0]   out_addr,
  output logic [COUNT_W-1:0]     out_count,
  output logic                   out_last,
  output logic                   busy,
  output logic [COUNT_W-1:0]     drop_count,
  output logic [COUNT_W-1:0]     oor_count
);

  localparam int ADDR_W = 2 * COORD_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;
  localparam logic [COORD_W-1:0] COORD_OOR = '1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;

  state_t state, state_next;

  logic [COUNT_W-1:0] mem [DEPTH];
  logic [COUNT_W-1:0] rd_data;
  logic [ADDR_W-1:0]  rd_addr, wr_addr, clr_addr;
  logic [COUNT_W-1:0] wr_data;
  logic               wr_en;

  logic               p1_valid;
  logic [ADDR_W-1:0]  p1_addr;
  logic               fwd_valid;
  logic [ADDR_W-1:0]  fwd_addr;
  logic [COUNT_W-1:0] fwd_data;
  logic [COUNT_W-1:0] inc_src, inc_val;

  logic [ADDR_W-1:0]  sample_addr;
  logic               in_range, take_sample, drop_event, accept_word;

  assign sample_addr = {i_bin_coord, q_bin_coord};
  assign in_range    = (i_bin_coord != COORD_OOR) && (q_bin_coord != COORD_OOR);
  assign take_sample = bin_valid && (state == ACCUM) && !start_dump && in_range;
  // Anything not taken by ACCUM is a drop, including samples in DRAIN and in the start_dump cycle.
  assign drop_event  = bin_valid && ((state != ACCUM) || start_dump);
  assign accept_word = out_valid && out_ready;
  assign busy        = (state == CLEAR) || (state == DUMP);
  assign out_count   = out_valid ? rd_data : '0;

  always_ff @(posedge clk100) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clr_addr == LAST_ADDR)         state_next = ACCUM;
      ACCUM: if (start_dump)                    state_next = DRAIN;
      DRAIN:                                    state_next = DUMP;
      DUMP:  if (accept_word && out_last)       state_next = CLEAR;
      default:                                  state_next = CLEAR;
    endcase
  end

  // The memory reads before it writes, so a repeat of last cycle's address takes the value just written.
  always_comb begin
    inc_src = (fwd_valid && (fwd_addr == p1_addr)) ? fwd_data : rd_data;
    inc_val = (inc_src == COUNT_MAX) ? inc_src : inc_src + COUNT_W'(1);
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    if (p1_valid) begin
      wr_en   = 1'b1;
      wr_addr = p1_addr;
      wr_data = inc_val;
    end else if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
    end else if ((state == DUMP) && accept_word) begin
      wr_en   = 1'b1;
      wr_addr = out_addr;
    end
    case (state)
      ACCUM:   rd_addr = sample_addr;
      DUMP:    rd_addr = accept_word ? out_addr + ADDR_W'(1) : out_addr;
      default: rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      clr_addr   <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_last   <= 1'b0;
      p1_valid   <= 1'b0;
      p1_addr    <= '0;
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
      drop_count <= '0;
    end else begin
      clr_addr  <= (state == CLEAR) ? clr_addr + ADDR_W'(1) : '0;
      p1_valid  <= take_sample;
      p1_addr   <= sample_addr;
      fwd_valid <= p1_valid;
      fwd_addr  <= p1_addr;
      fwd_data  <= inc_val;
      if (drop_event && (drop_count != COUNT_MAX)) drop_count <= drop_count + COUNT_W'(1);
      if (state == DRAIN) begin
        out_valid <= 1'b1;
        out_addr  <= '0;
        out_last  <= 1'b0;
      end else if ((state == DUMP) && accept_word) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_addr  <= '0;
          out_last  <= 1'b0;
        end else begin
          out_addr  <= out_addr + ADDR_W'(1);
          out_last  <= (out_addr + ADDR_W'(1)) == LAST_ADDR;
        end
      end
    end
  end

`ifdef HIST2D_OOR_COUNT_EN
  logic oor_event;
  assign oor_event = bin_valid && (state == ACCUM) && !start_dump && !in_range;

  always_ff @(posedge clk100) begin
    if (!rst_n)                                    oor_count <= '0;
    else if (oor_event && (oor_count != COUNT_MAX)) oor_count <= oor_count + COUNT_W'(1);
  end
`else
  assign oor_count = '0;
`endif

endmodule

// File: doc/hist2d_accum_ctrl.md
HIST2D_ACCUM_CTRL -- requirements
Module: hist2d_accum_ctrl

Interface
REQ-001 Parameter COORD_W, default 4; bit width of each bin coordinate. Memory depth is 2^(2*COORD_W).
REQ-002 Parameter COUNT_W, default 16; bit width of each bin count.
REQ-003 Port clk100, input, 1; the single clock. All logic is rising-edge.
REQ-004 Port rst_n, input, 1; reset, synchronous, active-low.
REQ-005 Port bin_valid, input, 1; one binned sample is presented this cycle.
REQ-006 Port i_bin_coord, input, COORD_W; i-axis bin. All-ones means out of range.
REQ-007 Port q_bin_coord, input, COORD_W; q-axis bin. All-ones means out of range.
REQ-008 Port start_dump, input, 1; single-cycle request to stream and clear the histogram.
REQ-009 Port out_ready, input, 1; downstream accepts the current output word.
REQ-010 Port out_valid, output, 1; out_addr, out_count and out_last are valid.
REQ-011 Port out_addr, output, 2*COORD_W; bin address, ordered {i_bin_coord, q_bin_coord}.
REQ-012 Port out_count, output, COUNT_W; count for out_addr.
REQ-013 Port out_last, output, 1; marks the final word of a dump.
REQ-014 Port busy, output, 1; high in CLEAR or DUMP.
REQ-015 Port drop_count, output, COUNT_W; saturating count of samples dropped while busy.
REQ-016 Port oor_count, output, COUNT_W; saturating count of out-of-range samples.

Function
REQ-017 The FSM SHALL have states CLEAR, ACCUM, DUMP, DRAIN.
  - CLEAR -> ACCUM after the last address has been written to zero.
  - ACCUM -> DRAIN on start_dump.
  - DRAIN -> DUMP once the accumulate pipeline is empty.
  - DUMP -> CLEAR after the word with out_last is accepted.
REQ-018 CLEAR SHALL write zero to addresses 0 through 2^(2*COORD_W)-1, one address per cycle, in ascending order.
REQ-019 In ACCUM, an in-range sample SHALL do a read-modify-write of mem[{i,q}]: read on cycle N, write count+1 on cycle N+1.
  - Result is visible to a dump read from cycle N+2.
  - Full throughput: one sample per cycle.
REQ-020 Back-to-back samples to the same address SHALL forward the pending write value, so every sample is counted.
REQ-021 Count increments SHALL saturate at 2^COUNT_W-1. drop_count and oor_count SHALL also saturate.
REQ-022 A sample with either coordinate all-ones SHALL NOT touch memory.
REQ-023 A bin_valid while busy=1 SHALL be discarded and SHALL increment drop_count. This includes a bin_valid in the same cycle as start_dump, because start_dump takes priority.
REQ-024 DRAIN SHALL last exactly 1 cycle.
REQ-025 In DUMP, addresses SHALL be read in ascending order from 0.
  - First out_valid occurs 2 cycles after the start_dump cycle, at the earliest.
  - One word per cycle while out_ready=1.
REQ-026 While out_valid=1 and out_ready=0, out_addr, out_count and out_last SHALL hold stable.
REQ-027 Each accepted word (out_valid and out_ready both high) SHALL write zero to its address. A dump therefore leaves memory cleared.
REQ-028 After a dump, the FSM SHALL still pass through CLEAR, which only re-zeroes memory. drop_count and oor_count are NOT reset by a dump.
REQ-029 start_dump SHALL be ignored outside ACCUM.

Reset
REQ-030 When rst_n=0 at a clock edge, outputs SHALL take these values:
  - out_valid, out_last: 0.
  - out_addr, out_count: 0.
  - drop_count, oor_count: 0.
  - busy: 1.
  - FSM: CLEAR at address 0.
REQ-031 A reset asserted during DUMP or an accumulate write SHALL abort that operation immediately. Memory contents are re-established only by the following CLEAR sweep.

Configuration
REQ-032 Macro HIST2D_OOR_COUNT_EN:
  - Defined: oor_count counts out-of-range samples accepted in ACCUM.
  - Undefined: oor_count is tied to 0 and its counter logic is omitted. Out-of-range samples are still discarded per REQ-022.

Verification
REQ-033 Clear sweep: release rst_n. Required: busy=1 for exactly 256 cycles, then busy=0; a subsequent dump returns out_count=0 for all 256 words.
REQ-034 Forwarding: send 5 consecutive samples to (3,7), then dump. Required: word at out_addr=0x37 has out_count=5 and all other words are 0.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles mid-dump at out_addr=0x10. Required: outputs stay stable; no address is skipped or duplicated; out_last=1 only on out_addr=0xFF.
REQ-036 Saturation, with COUNT_W=4: send 20 samples to (1,1). Required: dumped count=15.
REQ-037 Dropping: assert bin_valid each cycle for 3 cycles starting with the start_dump cycle, then 2 more during DUMP. Required: drop_count=5 and none of these samples are counted.
REQ-038 Out of range, with HIST2D_OOR_COUNT_EN defined: send samples (15,2), (2,15), (4,4). Required: oor_count=2 and only 0x44 has count 1. Repeat undefined; required: oor_count=0.
